// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a FIFO_DEPTH-entry byte FIFO.
// Define UART_TX_PARITY_EN to send 8E1 frames (even parity bit after the data bits).
module uart_tx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic [CW-1:0] clk_count, clk_count_n;
  logic [2:0] bit_index, bit_index_n;
  logic [7:0] shift, shift_n;
  logic tx_n, push, pop, bit_end, empty;
  assign empty = count == '0;
  assign data_ready = count != FULL;
  assign busy = state != IDLE || !empty;
  assign push = data_valid && data_ready;
  assign bit_end = clk_count == LAST;
  always_comb begin
    state_n = state;
    clk_count_n = bit_end ? '0 : clk_count + 1'b1;
    bit_index_n = bit_index;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        clk_count_n = '0;
        pop = !empty;
        shift_n = empty ? shift : mem[rd_ptr];
        state_n = empty ? IDLE : START;
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_index_n = '0;
      end
      DATA: if (bit_end) begin
        bit_index_n = bit_index + 1'b1;
`ifdef UART_TX_PARITY_EN
        state_n = bit_index == 3'd7 ? PARITY : DATA;
`else
        state_n = bit_index == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = bit_end ? STOP : PARITY;
`endif
      STOP: if (bit_end) begin
        // chain straight into the next start bit so queued frames leave no idle gap
        pop = !empty;
        shift_n = empty ? shift : mem[rd_ptr];
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the start bit appears on the pop edge itself
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[bit_index_n] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state_n == PARITY) tx_n = ^shift_n;
`endif
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift <= '0;
      tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      clk_count <= clk_count_n;
      bit_index <= bit_index_n;
      shift <= shift_n;
      tx <= tx_n;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + NW'(push) - NW'(pop);
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at 16 clocks per bit; a tx-line decoder checks every frame.
module tb_uart_tx;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, rst_n = 0, data_valid = 0;
  logic [7:0] data_in = 8'h00;
  logic data_ready, tx, busy;
  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  uart_tx #(.CLOCK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
  // Waits (bounded) for a start bit, then samples every bit for CPB clocks; returns on the last stop-bit clock.
  task automatic get_frame(output logic [7:0] b, output logic [NB-1:0] bits, output int w, output logic stable);
    w = 0;
    stable = 1'b1;
    bits = '0;
    b = 8'hxx;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      stable = 1'b0;
      return;
    end
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < CPB; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (j == 0) bits[k] = tx;
        else if (tx !== bits[k]) stable = 1'b0;
      end
    b = bits[8:1];
  endtask
  task automatic test_reset;
    rst_n = 0;
    data_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", data_ready); end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_single;
    logic [7:0] b, e;
    logic [NB-1:0] bits;
    int w;
    logic st;
    data_valid = 1;
    data_in = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    data_valid = 0;
    data_in = 8'hA0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_before_pop: got %b want 1", tx); end
    get_frame(b, bits, w, st);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", w); end
    e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
    n_checks++; if (b !== e) begin n_fail++; $display("FAIL single_data: got %h want %h", b, e); end
    n_checks++; if ({st, bits[0], bits[NB-1]} !== 3'b101) begin n_fail++; $display("FAIL single_framing: got %b want 101", {st, bits[0], bits[NB-1]}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last_clk: got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if ({busy, tx} !== 2'b01) begin n_fail++; $display("FAIL single_busy_fall: got busy,tx=%b want 01", {busy, tx}); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] v [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          data_valid = 1;
          data_in = v[i];
          n_checks++; if (data_ready !== (i < 5)) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want %b", i, data_ready, i < 5); end
          if (i < 5) exp_q.push_back(v[i]);
          @(negedge clk);
        end
        data_valid = 0;
      end
      begin
        logic [7:0] b, e;
        logic [NB-1:0] bits;
        int w;
        logic st;
        for (int f = 0; f < 5; f++) begin
          if (f != 0) @(negedge clk);
          if (f == 1) begin
            n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_return: got %b want 1", data_ready); end
          end
          get_frame(b, bits, w, st);
          n_checks++; if (w !== (f == 0 ? 2 : 0)) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d want %0d", f, w, f == 0 ? 2 : 0); end
          e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
          n_checks++; if (b !== e) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", f, b, e); end
          n_checks++; if ({st, bits[0], bits[NB-1]} !== 3'b101) begin n_fail++; $display("FAIL b2b_framing_%0d: got %b want 101", f, {st, bits[0], bits[NB-1]}); end
          if (f == 0) begin
            n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held_low: got %b want 0", data_ready); end
          end
        end
      end
    join
    @(negedge clk);
    n_checks++; if ({busy, tx} !== 2'b01) begin n_fail++; $display("FAIL b2b_idle_after: got busy,tx=%b want 01", {busy, tx}); end
  endtask
  task automatic test_reset_mid;
    int bad = 0;
    data_valid = 1;
    data_in = 8'hFF;
    @(negedge clk);
    data_in = 8'h11;
    @(negedge clk);
    data_in = 8'h22;
    @(negedge clk);
    data_valid = 0;
    repeat (68) @(negedge clk);
    n_checks++; if ({busy, tx} !== 2'b11) begin n_fail++; $display("FAIL rmid_in_bit3: got busy,tx=%b want 11", {busy, tx}); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_checks++; if ({tx, busy, data_ready} !== 3'b101) begin n_fail++; $display("FAIL rmid_after_reset: got tx,busy,ready=%b want 101", {tx, busy, data_ready}); end
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_no_frames: got %0d active clks want 0", bad); end
  endtask
  task automatic test_full;
    logic [7:0] v [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h3C};
    fork
      begin
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
          data_valid = 1;
          data_in = v[i];
          exp_q.push_back(v[i]);
          @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
          data_in = 8'hEE;
          if (data_ready !== 1'b0) bad++;
          @(negedge clk);
        end
        data_valid = 0;
        data_in = 8'h00;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_ready_low: got %0d ready clks want 0", bad); end
      end
      begin
        logic [7:0] b, e;
        logic [NB-1:0] bits;
        int w;
        logic st;
        for (int f = 0; f < 5; f++) begin
          if (f != 0) @(negedge clk);
          get_frame(b, bits, w, st);
          e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
          n_checks++; if (b !== e || st !== 1'b1 || bits[NB-1] !== 1'b1) begin n_fail++; $display("FAIL full_data_%0d: got %h (stable %b stop %b) want %h", f, b, st, bits[NB-1], e); end
        end
      end
    join
    begin
      int starts = 0;
      repeat (300) begin
        @(negedge clk);
        if (tx !== 1'b1) starts++;
      end
      n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL full_no_extra_frame: got %0d low clks want 0", starts); end
    end
  endtask
  task automatic test_parity;
`ifdef UART_TX_PARITY_EN
    logic [7:0] v [2] = '{8'h07, 8'h03};
    logic p [2] = '{1'b1, 1'b0};
    logic [7:0] b;
    logic [NB-1:0] bits;
    int w;
    logic st;
    data_valid = 1;
    data_in = v[0];
    @(negedge clk);
    data_in = v[1];
    @(negedge clk);
    data_valid = 0;
    for (int f = 0; f < 2; f++) begin
      if (f != 0) @(negedge clk);
      get_frame(b, bits, w, st);
      n_checks++; if (b !== v[f]) begin n_fail++; $display("FAIL parity_data_%0d: got %h want %h", f, b, v[f]); end
      n_checks++; if (bits[9] !== p[f]) begin n_fail++; $display("FAIL parity_bit_%0d: got %b want %b", f, bits[9], p[f]); end
      n_checks++; if ({st, bits[0], bits[10]} !== 3'b101) begin n_fail++; $display("FAIL parity_framing_%0d: got %b want 101", f, {st, bits[0], bits[10]}); end
    end
    @(negedge clk);
`endif
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_reset_mid;
    test_full;
    test_parity;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
